pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline event inputs and per-stage stall/clear requests
// Pipe-side events:
//   LOAD_USE_HZ, MC_START, DMEM_WAIT, BR_REDIRECT, TRAP.
// Controller-side requests:
//   IF_STALL, <stage>_STALL/<stage>_CLEAR for ID1..WB2, and BUSY.
//   STALL_CYC/FLUSH_CNT are present only with PIPE_CTRL_PERF_EN.
// Modports:
//   master = pipe side, slave = controller side.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
   logic LOAD_USE_HZ, MC_START, DMEM_WAIT, BR_REDIRECT, TRAP;
   logic IF_STALL;
   logic ID1_STALL, ID2_STALL, EX1_STALL, EX2_STALL, ME1_STALL, ME2_STALL, WB1_STALL, WB2_STALL;
   logic ID1_CLEAR, ID2_CLEAR, EX1_CLEAR, EX2_CLEAR, ME1_CLEAR, ME2_CLEAR, WB1_CLEAR, WB2_CLEAR;
   logic BUSY;
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] STALL_CYC, FLUSH_CNT;
`endif
   modport master (
      output LOAD_USE_HZ, MC_START, DMEM_WAIT, BR_REDIRECT, TRAP,
      input  IF_STALL,
             ID1_STALL, ID2_STALL, EX1_STALL, EX2_STALL, ME1_STALL, ME2_STALL, WB1_STALL, WB2_STALL,
             ID1_CLEAR, ID2_CLEAR, EX1_CLEAR, EX2_CLEAR, ME1_CLEAR, ME2_CLEAR, WB1_CLEAR, WB2_CLEAR,
             BUSY
`ifdef PIPE_CTRL_PERF_EN
      , input STALL_CYC, FLUSH_CNT
`endif
   );
   modport slave (
      input  LOAD_USE_HZ, MC_START, DMEM_WAIT, BR_REDIRECT, TRAP,
      output IF_STALL,
             ID1_STALL, ID2_STALL, EX1_STALL, EX2_STALL, ME1_STALL, ME2_STALL, WB1_STALL, WB2_STALL,
             ID1_CLEAR, ID2_CLEAR, EX1_CLEAR, EX2_CLEAR, ME1_CLEAR, ME2_CLEAR, WB1_CLEAR, WB2_CLEAR,
             BUSY
`ifdef PIPE_CTRL_PERF_EN
      , output STALL_CYC, FLUSH_CNT
`endif
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage stall/clear sequencing for the nine-stage core pipe
// Ports:
//   CLK  core clock
//   RST  synchronous active-high reset
//   bus  pipe_hazard_ctrl_if.slave (events in, stall/clear/BUSY out)
// Stage index: IF=0 ID1=1 ID2=2 EX1=3 EX2=4 ME1=5 ME2=6 WB1=7 WB2=8.
// Optional: define PIPE_CTRL_PERF_EN to add STALL_CYC/FLUSH_CNT counters.
module pipe_hazard_ctrl #(
   parameter int MC_LAT   = 4,
   parameter int RST_HOLD = 2,
   parameter int CNT_W    = 32
) (
   input logic CLK,
   input logic RST,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {HOLD, RUN, MC} state_t;
   state_t state, state_n;
   logic [3:0] hold_cnt, hold_cnt_n, mc_cnt, mc_cnt_n;
   logic redir_pend, redir_pend_n;
   logic [8:0] stall;
   logic [8:1] clear;
   logic mc_act, ex2_stall, redir;
   // A single-cycle op (MC_LAT=1) never stalls EX2.
   assign mc_act = (state == MC) || (bus.MC_START && MC_LAT > 1);
   assign ex2_stall = bus.DMEM_WAIT || mc_act;
   assign redir = bus.BR_REDIRECT || redir_pend;
   always_comb begin
      state_n = state;
      hold_cnt_n = hold_cnt;
      mc_cnt_n = mc_cnt;
      redir_pend_n = redir_pend;
      stall = '0;
      clear = '0;
      if (RST) begin
         stall[0] = 1'b1;
         clear = '1;
      end else if (bus.TRAP) begin
         clear[7:1] = '1;
         state_n = RUN;
         mc_cnt_n = '0;
         redir_pend_n = 1'b0;
      end else if (state == HOLD) begin
         stall[0] = 1'b1;
         clear[1] = 1'b1;
         hold_cnt_n = hold_cnt - 4'd1;
         state_n = (hold_cnt <= 4'd1) ? RUN : HOLD;
      end else begin
         if (bus.DMEM_WAIT) begin
            stall[6:0] = '1;
            clear[7] = 1'b1;
         end else if (mc_act) begin
            stall[4:0] = '1;
            clear[5] = 1'b1;
         end else if (bus.LOAD_USE_HZ) begin
            stall[2:0] = '1;
            clear[3] = 1'b1;
         end
         // With EX2 free any active stall is at ID2 or younger, so the flush covers it.
         if (redir && !ex2_stall) begin
            stall[3:0] = '0;
            clear[3:1] = '1;
            redir_pend_n = 1'b0;
         end else if (redir) begin
            redir_pend_n = 1'b1;
         end
         // The MC_START cycle is the first stall cycle, so MC itself lasts MC_LAT-2 cycles.
         if (state == MC) begin
            mc_cnt_n = mc_cnt - 4'd1;
            state_n = (mc_cnt <= 4'd1) ? RUN : MC;
         end else if (bus.MC_START && MC_LAT > 2) begin
            mc_cnt_n = 4'(MC_LAT - 2);
            state_n = MC;
         end
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= (RST_HOLD == 0) ? RUN : HOLD;
         hold_cnt <= 4'(RST_HOLD);
         mc_cnt <= '0;
         redir_pend <= 1'b0;
      end else begin
         state <= state_n;
         hold_cnt <= hold_cnt_n;
         mc_cnt <= mc_cnt_n;
         redir_pend <= redir_pend_n;
      end
   end
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cyc, flush_cnt;
   logic redir_apply;
   assign redir_apply = !RST && !bus.TRAP && state != HOLD && redir && !ex2_stall;
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cyc <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall[0] && state != HOLD && !(&stall_cyc)) stall_cyc <= stall_cyc + CNT_W'(1);
         if ((bus.TRAP || redir_apply) && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
   assign bus.STALL_CYC = stall_cyc;
   assign bus.FLUSH_CNT = flush_cnt;
`endif
   assign bus.IF_STALL  = stall[0];
   assign bus.ID1_STALL = stall[1];
   assign bus.ID2_STALL = stall[2];
   assign bus.EX1_STALL = stall[3];
   assign bus.EX2_STALL = stall[4];
   assign bus.ME1_STALL = stall[5];
   assign bus.ME2_STALL = stall[6];
   assign bus.WB1_STALL = stall[7];
   assign bus.WB2_STALL = stall[8];
   assign bus.ID1_CLEAR = clear[1];
   assign bus.ID2_CLEAR = clear[2];
   assign bus.EX1_CLEAR = clear[3];
   assign bus.EX2_CLEAR = clear[4];
   assign bus.ME1_CLEAR = clear[5];
   assign bus.ME2_CLEAR = clear[6];
   assign bus.WB1_CLEAR = clear[7];
   assign bus.WB2_CLEAR = clear[8];
   assign bus.BUSY = (state != RUN) || redir_pend;
endmodule
